// File: rtl/ssio_sdr_in_delay_cal_if.sv
// Calibration controller bus: start/captured data in, delay-line controls and status out.
interface ssio_sdr_in_delay_cal_if #(
    parameter int WIDTH     = 1,
    parameter int TAP_WIDTH = 5
);
    logic                 start;
    logic [WIDTH-1:0]     data_in;
    logic [TAP_WIDTH-1:0] delay_tap;
    logic                 delay_load;
    logic                 busy;
    logic                 done;
    logic                 locked;
    logic                 error;
    logic [TAP_WIDTH-1:0] win_start;
    logic [TAP_WIDTH:0]   win_len;

    modport master (
        input  start, data_in,
        output delay_tap, delay_load, busy, done,
        output locked, error, win_start, win_len
    );

    modport slave (
        output start, data_in,
        input  delay_tap, delay_load, busy, done,
        input  locked, error, win_start, win_len
    );
endinterface

// File: rtl/ssio_sdr_in_delay_cal.sv
// SDR input-delay calibration: sweep all taps against a toggle pattern,
// keep the longest contiguous passing window and load its centre tap.
module ssio_sdr_in_delay_cal #(
    parameter int WIDTH         = 1,
    parameter int TAP_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 64,
    parameter int MIN_WINDOW    = 4
) (
    input  logic clk,
    input  logic rst,
    ssio_sdr_in_delay_cal_if.master bus
);
    localparam int LW   = TAP_WIDTH + 1;
    localparam int CMAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        IDLE, SET_TAP, SETTLE, CHECK, EVAL, FINISH, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TAP_WIDTH-1:0] tap_q, tap_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 fail_q, fail_d;
    logic                 run_open_q, run_open_d;
    logic [TAP_WIDTH-1:0] run_start_q, run_start_d;
    logic [LW-1:0]        run_len_q, run_len_d;
    logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
    logic [LW-1:0]        best_len_q, best_len_d;
    logic [TAP_WIDTH-1:0] delay_tap_q, delay_tap_d;
    logic                 delay_load_q, delay_load_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 locked_q, locked_d;
    logic                 error_q, error_d;
    logic [TAP_WIDTH-1:0] win_start_q, win_start_d;
    logic [LW-1:0]        win_len_q, win_len_d;
    logic                 last_tap;
    logic [TAP_WIDTH-1:0] centre;

    assign last_tap = (tap_q == {TAP_WIDTH{1'b1}});
    // Lower-middle tap of the window; the sum never exceeds the last tap.
    assign centre = best_start_q + TAP_WIDTH'((best_len_q - LW'(1)) >> 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tap_d        = tap_q;
        prev_d       = bus.data_in;
        fail_d       = fail_q;
        run_open_d   = run_open_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        delay_tap_d  = delay_tap_q;
        delay_load_d = 1'b0;
        done_d       = 1'b0;
        locked_d     = locked_q;
        error_d      = error_q;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    locked_d     = 1'b0;
                    error_d      = 1'b0;
                    win_start_d  = '0;
                    win_len_d    = '0;
                    run_open_d   = 1'b0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                    tap_d        = '0;
                    delay_tap_d  = '0;
                    delay_load_d = 1'b1;
                    state_d      = SET_TAP;
                end
            end
            SET_TAP: begin
                cnt_d   = '0;
                fail_d  = 1'b0;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.data_in != ~prev_q) fail_d = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CHECK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (!fail_q) begin
                    if (!run_open_q) begin
                        run_open_d  = 1'b1;
                        run_start_d = tap_q;
                        run_len_d   = LW'(1);
                    end else begin
                        run_len_d = run_len_q + LW'(1);
                    end
                end
                if (fail_q || last_tap) begin
                    if (run_len_d > best_len_q) begin
                        best_start_d = run_start_d;
                        best_len_d   = run_len_d;
                    end
                    run_open_d = 1'b0;
                    run_len_d  = '0;
                end
                if (last_tap) begin
                    state_d = FINISH;
                end else begin
                    tap_d        = tap_q + TAP_WIDTH'(1);
                    delay_tap_d  = tap_q + TAP_WIDTH'(1);
                    delay_load_d = 1'b1;
                    state_d      = SET_TAP;
                end
            end
            FINISH: begin
                if (best_len_q >= LW'(MIN_WINDOW)) begin
                    delay_tap_d = centre;
                    locked_d    = 1'b1;
                end else begin
                    delay_tap_d = '0;
                    error_d     = 1'b1;
                end
                delay_load_d = 1'b1;
                win_start_d  = best_start_q;
                win_len_d    = best_len_q;
                done_d       = 1'b1;
                state_d      = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            prev_q       <= '0;
            fail_q       <= 1'b0;
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            delay_tap_q  <= '0;
            delay_load_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            win_start_q  <= '0;
            win_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            prev_q       <= prev_d;
            fail_q       <= fail_d;
            run_open_q   <= run_open_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            delay_tap_q  <= delay_tap_d;
            delay_load_q <= delay_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
        end
    end

    assign bus.delay_tap  = delay_tap_q;
    assign bus.delay_load = delay_load_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.locked     = locked_q;
    assign bus.error      = error_q;
    assign bus.win_start  = win_start_q;
    assign bus.win_len    = win_len_q;
endmodule

// File: tb/tb_ssio_sdr_in_delay_cal.sv
// Bench for ssio_sdr_in_delay_cal: eye-mask channel model, queued expectations,
// done-triggered monitor.
module tb_ssio_sdr_in_delay_cal;
    localparam int W  = 4;
    localparam int TW = 5;
    localparam int NT = 32;
    localparam int DONE_CYC = 32 * 82 + 2;

    typedef struct {
        int ws;
        int wl;
        int tap;
        int lk;
        int er;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssio_sdr_in_delay_cal_if #(.WIDTH(W), .TAP_WIDTH(TW)) bus ();

    ssio_sdr_in_delay_cal #(
        .WIDTH(W), .TAP_WIDTH(TW), .SETTLE_CYCLES(16),
        .CHECK_CYCLES(64), .MIN_WINDOW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int edges    = 0;
    int t0       = 0;
    int done_seen = 0;
    exp_t exp_q[$];

    logic [NT-1:0] pmask = '0;
    bit            stuck = 1'b0;
    int            cur_tap = 0;
    logic [W-1:0]  tog = 4'b0101;
    logic [W-1:0]  last_d = '0;

    task automatic check(string nm, int act, int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic exp_t model(logic [NT-1:0] m, bit stk);
        exp_t e;
        int bs = 0, bl = 0, l;
        bit pb = 1'b0;
        if (stk) m = '0;
        for (int s = 0; s < NT; s++) begin
            if (m[s] && !pb) begin
                l = 0;
                while (s + l < NT && m[s+l]) l++;
                if (l > bl) begin
                    bl = l;
                    bs = s;
                end
            end
            pb = m[s];
        end
        e.ws = bs;
        e.wl = bl;
        e.lk = (bl >= 4) ? 1 : 0;
        e.er = (bl >= 4) ? 0 : 1;
        e.tap = (bl >= 4) ? bs + (bl - 1) / 2 : 0;
        return e;
    endfunction

    function automatic logic [NT-1:0] win(int s, int e);
        logic [NT-1:0] m = '0;
        for (int i = s; i <= e; i++) m[i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) edges++;

    always @(negedge clk)
        if (bus.delay_load) cur_tap = int'(bus.delay_tap);

    // Channel: passing taps carry a clean per-lane toggle, failing taps
    // carry noise with at least one lane that does not toggle.
    always @(posedge clk) begin
        logic [W-1:0] d;
        int k;
        #1;
        tog = ~tog;
        if (pmask[cur_tap] && !stuck) begin
            d = tog;
        end else if (pmask[cur_tap] && stuck) begin
            d = tog;
            d[0] = 1'b0;
        end else begin
            d = W'($urandom);
            k = $urandom_range(0, W - 1);
            d[k] = last_d[k];
        end
        last_d = d;
        bus.data_in = d;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", edges - t0 + 1, DONE_CYC);
                check("win_start", int'(bus.win_start), e.ws);
                check("win_len", int'(bus.win_len), e.wl);
                check("delay_tap", int'(bus.delay_tap), e.tap);
                check("delay_load", int'(bus.delay_load), 1);
                check("locked", int'(bus.locked), e.lk);
                check("error", int'(bus.error), e.er);
                check("busy_done", int'(bus.busy), 1);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t0 = edges;
        bus.start = 1'b0;
        check("first_load", int'(bus.delay_load), 1);
        check("first_tap", int'(bus.delay_tap), 0);
        check("busy_start", int'(bus.busy), 1);
    endtask

    task automatic run(logic [NT-1:0] m, bit stk, bit poke);
        int seen0;
        int n;
        bit got;
        pmask = m;
        stuck = stk;
        exp_q.push_back(model(m, stk));
        seen0 = done_seen;
        got = 1'b0;
        pulse_start();
        for (n = 2; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (poke) bus.start = (n == 500);
            #1;
            if (done_seen != seen0) got = 1'b1;
        end
        bus.start = 1'b0;
        if (!got) begin
            check("timeout", 0, 1);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        check("idle_after", int'(bus.busy), 0);
        check("single_done", done_seen - seen0, 1);
    endtask

    initial begin
        logic [NT-1:0] m;
        int s, l;
        bus.start = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_tap", int'(bus.delay_tap), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_winlen", int'(bus.win_len), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run('1, 1'b0, 1'b0);
        run(win(8, 20), 1'b0, 1'b0);
        run(win(2, 5) | win(10, 20), 1'b0, 1'b0);
        run(win(2, 5) | win(10, 13), 1'b0, 1'b0);
        run(win(26, 31), 1'b0, 1'b0);
        run('1, 1'b1, 1'b0);
        run(win(3, 5), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            s = $urandom_range(0, NT - 1);
            l = $urandom_range(1, NT - s);
            m = win(s, s + l - 1);
            if ($urandom_range(0, 1) == 1) m = m | win(0, $urandom_range(0, 3));
            run(m, 1'b0, 1'b0);
        end
        run(NT'($urandom), 1'b0, 1'b0);

        // Reset in the middle of tap 9's check window.
        pmask = '1;
        stuck = 1'b0;
        pulse_start();
        while (edges - t0 + 1 < 780) @(negedge clk);
        check("pre_rst_tap", int'(bus.delay_tap), 9);
        rst = 1'b1;
        #1;
        check("mid_rst_tap", int'(bus.delay_tap), 0);
        check("mid_rst_load", int'(bus.delay_load), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_lock", int'(bus.locked), 0);
        check("mid_rst_err", int'(bus.error), 0);
        check("mid_rst_ws", int'(bus.win_start), 0);
        check("mid_rst_wl", int'(bus.win_len), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", int'(bus.busy), 0);

        run('1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
